// File: rtl/cr16_defs_pkg.sv
// CR16-subset field encodings, ALU/source-B selects and control FSM states.
// Pure definitions: no latency or backpressure of its own.
package cr16_defs;

  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  // ALU operations share one code space for op (immediate form) and ext (register form)
  localparam logic [3:0] C_ADD = 4'b0101;
  localparam logic [3:0] C_SUB = 4'b1001;
  localparam logic [3:0] C_AND = 4'b0001;
  localparam logic [3:0] C_OR  = 4'b0010;
  localparam logic [3:0] C_XOR = 4'b0011;
  localparam logic [3:0] C_CMP = 4'b1011;
  localparam logic [3:0] C_MOV = 4'b1101;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_UC = 4'b1110;

  localparam int FLG_N = 4;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011,
    ALU_XOR = 3'b100, ALU_CMP = 3'b101, ALU_MOV = 3'b110
  } alucont_e;

  typedef enum logic [1:0] {
    SRCB_REG = 2'b00, SRCB_ONE = 2'b01, SRCB_SEXT = 2'b10, SRCB_ZEXT = 2'b11
  } alusrcb_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_ALU, S_MEM_RD, S_LOAD_WB,
    S_MEM_WR, S_BRANCH, S_JCOND, S_JAL_WB
  } state_e;

  function automatic logic is_alu_code(input logic [3:0] c);
    return c inside {C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_CMP, C_MOV};
  endfunction

  function automatic logic is_logical(input logic [3:0] c);
    return c inside {C_AND, C_OR, C_XOR};
  endfunction

  function automatic alucont_e alu_of(input logic [3:0] c);
    case (c)
      C_SUB:   return ALU_SUB;
      C_AND:   return ALU_AND;
      C_OR:    return ALU_OR;
      C_XOR:   return ALU_XOR;
      C_CMP:   return ALU_CMP;
      C_MOV:   return ALU_MOV;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/controller_cond_eval.sv
// Branch/jump condition evaluator: condition code + {N,Z,F,L,C} -> taken.
// Purely combinational, zero latency, no backpressure.
module cond_eval
  import cr16_defs::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flag,
  output logic       taken
);

  logic unused_flags;
  assign unused_flags = ^flag[2:1];

  always_comb begin
    case (cond)
      CC_EQ:   taken = flag[FLG_Z];
      CC_NE:   taken = !flag[FLG_Z];
      CC_CS:   taken = flag[FLG_C];
      CC_CC:   taken = !flag[FLG_C];
      CC_GT:   taken = flag[FLG_N];
      CC_LE:   taken = !flag[FLG_N];
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Multicycle fetch/decode/execute sequencer driving the datapath; 3 cycles per op (LOAD 4).
// Memory states hold mem_req until mem_ready; each wait cycle adds one cycle of latency.
module controller
  import cr16_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic [4:0]  flag,
  input  logic        mem_ready,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [15:0] immediate,
  output logic        regwrt,
  output logic        memtoreg,
  output logic        pcen,
  output logic        regdst,
  output logic        branch,
  output logic        jump,
  output logic        jal,
  output logic        ir_mux,
  output logic        pc_mux,
  output logic [1:0]  alusrcb,
  output logic [2:0]  alucont,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        flag_en,
  output logic        illegal
);

  state_e     state_q, state_d;
  logic [3:0] op, ext, code;
  logic       is_imm, taken;

  assign op     = instruction[15:12];
  assign ext    = instruction[7:4];
  assign is_imm = (op != OP_REG);
  assign code   = is_imm ? op : ext;

  cond_eval u_cond_eval (
    .cond  (instruction[11:8]),
    .flag  (flag),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ra        = '0;
    rb        = '0;
    immediate = '0;
    regwrt    = 1'b0;
    memtoreg  = 1'b0;
    pcen      = 1'b0;
    regdst    = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    jal       = 1'b0;
    ir_mux    = 1'b0;
    pc_mux    = 1'b0;
    alusrcb   = SRCB_REG;
    alucont   = ALU_ADD;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    flag_en   = 1'b0;
    illegal   = 1'b0;
    // Reset gates every output combinationally so an in-flight access is dropped at once
    if (reset) begin
      ra        = instruction[11:8];
      rb        = instruction[3:0];
      immediate = is_logical(op) ? {8'h00, instruction[7:0]}
                                 : {{8{instruction[7]}}, instruction[7:0]};
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_mux  = 1'b1;
            pcen    = 1'b1;
            alusrcb = SRCB_ONE;
            alucont = ALU_ADD;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_alu_code(code))                        state_d = S_EXEC_ALU;
          else if (op == OP_MEM && ext == EXT_LOAD)     state_d = S_MEM_RD;
          else if (op == OP_MEM && ext == EXT_STOR)     state_d = S_MEM_WR;
          else if (op == OP_MEM && ext == EXT_JAL)      state_d = S_JAL_WB;
          else if (op == OP_MEM && ext == EXT_JCOND)    state_d = S_JCOND;
          else if (op == OP_BCOND)                      state_d = S_BRANCH;
          else begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_EXEC_ALU: begin
          alucont = alu_of(code);
          alusrcb = !is_imm ? SRCB_REG : (is_logical(code) ? SRCB_ZEXT : SRCB_SEXT);
          regwrt  = (code != C_CMP);
          flag_en = code inside {C_ADD, C_SUB, C_CMP};
          state_d = S_FETCH;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_LOAD_WB;
        end
        S_LOAD_WB: begin
          regwrt   = 1'b1;
          memtoreg = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_BRANCH: begin
          if (taken) begin
            pcen    = 1'b1;
            branch  = 1'b1;
            pc_mux  = 1'b1;
            alusrcb = SRCB_SEXT;
            alucont = ALU_ADD;
          end
          state_d = S_FETCH;
        end
        S_JCOND: begin
          if (taken) begin
            pcen = 1'b1;
            jump = 1'b1;
          end
          state_d = S_FETCH;
        end
        S_JAL_WB: begin
          regwrt  = 1'b1;
          jal     = 1'b1;
          pcen    = 1'b1;
          jump    = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_controller.sv
// Bench for controller: per-cycle outputs compared against an instruction-level trace model.
// Directed vector table, reset corner sequences, then randomized instructions and wait states.
module tb_controller;

  logic        clk, reset, mem_ready;
  logic [15:0] instruction;
  logic [4:0]  flag;
  logic [3:0]  ra, rb;
  logic [15:0] immediate;
  logic        regwrt, memtoreg, pcen, regdst, branch, jump, jal, ir_mux, pc_mux;
  logic [1:0]  alusrcb;
  logic [2:0]  alucont;
  logic        mem_req, mem_we, iord, flag_en, illegal;

  controller dut (
    .clk(clk), .reset(reset), .instruction(instruction), .flag(flag), .mem_ready(mem_ready),
    .ra(ra), .rb(rb), .immediate(immediate), .regwrt(regwrt), .memtoreg(memtoreg),
    .pcen(pcen), .regdst(regdst), .branch(branch), .jump(jump), .jal(jal),
    .ir_mux(ir_mux), .pc_mux(pc_mux), .alusrcb(alusrcb), .alucont(alucont),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .flag_en(flag_en), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] imm;
    logic regwrt, memtoreg, pcen, regdst, branch, jump, jal, ir_mux, pc_mux;
    logic [1:0]  alusrcb;
    logic [2:0]  alucont;
    logic mem_req, mem_we, iord, flag_en, illegal;
  } out_t;

  typedef struct { logic rdy; out_t exp; } step_t;
  typedef struct { string name; logic [15:0] ir; logic [4:0] fl; int fw; int dw; int cycles; } vec_t;
  typedef enum { K_ALU, K_LOAD, K_STOR, K_JAL, K_JCOND, K_BR, K_ILL } kind_e;

  out_t  act;
  step_t trace[$];
  int    checks = 0;
  int    errors = 0;

  assign act = {ra, rb, immediate, regwrt, memtoreg, pcen, regdst, branch, jump, jal,
                ir_mux, pc_mux, alusrcb, alucont, mem_req, mem_we, iord, flag_en, illegal};

  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  // ALU operation index 0..6 = ADD,SUB,AND,OR,XOR,CMP,MOV, which is also its alucont value
  function automatic int alu_index(input logic [3:0] c);
    case (c)
      4'h5: return 0;
      4'h9: return 1;
      4'h1: return 2;
      4'h2: return 3;
      4'h3: return 4;
      4'hB: return 5;
      4'hD: return 6;
      default: return -1;
    endcase
  endfunction

  function automatic kind_e kind_of(input logic [15:0] ir);
    if (ir[15:12] == 4'h0) return (alu_index(ir[7:4]) >= 0) ? K_ALU : K_ILL;
    if (alu_index(ir[15:12]) >= 0) return K_ALU;
    if (ir[15:12] == 4'hC) return K_BR;
    if (ir[15:12] == 4'h4) begin
      case (ir[7:4])
        4'h0: return K_LOAD;
        4'h4: return K_STOR;
        4'h8: return K_JAL;
        4'hC: return K_JCOND;
        default: return K_ILL;
      endcase
    end
    return K_ILL;
  endfunction

  function automatic bit cond_true(input logic [3:0] cc, input logic [4:0] fl);
    bit n, z, c;
    n = fl[4]; z = fl[3]; c = fl[0];
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd6:  return n;
      4'd7:  return !n;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic out_t base_out(input logic [15:0] ir);
    out_t o;
    int   v;
    o    = '0;
    o.ra = ir[11:8];
    o.rb = ir[3:0];
    v    = int'(ir[7:0]);
    if (ir[15:12] inside {4'h1, 4'h2, 4'h3}) o.imm = 16'(v);
    else                                     o.imm = 16'((v >= 128) ? v - 256 : v);
    return o;
  endfunction

  task automatic push(input logic r, input out_t e);
    trace.push_back('{rdy: r, exp: e});
  endtask

  task automatic build_trace(input logic [15:0] ir, input logic [4:0] fl, input int fw, input int dw);
    out_t  b, e;
    kind_e k;
    int    ai;
    trace.delete();
    b  = base_out(ir);
    k  = kind_of(ir);
    ai = (ir[15:12] == 4'h0) ? alu_index(ir[7:4]) : alu_index(ir[15:12]);
    e = b; e.mem_req = 1'b1;
    for (int j = 0; j < fw; j++) push(1'b0, e);
    e.ir_mux = 1'b1; e.pcen = 1'b1; e.alusrcb = 2'd1; e.alucont = 3'd0;
    push(1'b1, e);
    e = b; e.illegal = (k == K_ILL);
    push(1'($urandom_range(0, 1)), e);
    e = b;
    case (k)
      K_ALU: begin
        e.alucont = 3'(ai);
        if (ir[15:12] == 4'h0) e.alusrcb = 2'd0;
        else                   e.alusrcb = (ai inside {2, 3, 4}) ? 2'd3 : 2'd2;
        e.regwrt  = (ai != 5);
        e.flag_en = (ai inside {0, 1, 5});
        push(1'($urandom_range(0, 1)), e);
      end
      K_LOAD: begin
        e.mem_req = 1'b1; e.iord = 1'b1;
        for (int j = 0; j < dw; j++) push(1'b0, e);
        push(1'b1, e);
        e = b; e.regwrt = 1'b1; e.memtoreg = 1'b1;
        push(1'($urandom_range(0, 1)), e);
      end
      K_STOR: begin
        e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1;
        for (int j = 0; j < dw; j++) push(1'b0, e);
        push(1'b1, e);
      end
      K_JAL: begin
        e.regwrt = 1'b1; e.jal = 1'b1; e.pcen = 1'b1; e.jump = 1'b1;
        push(1'($urandom_range(0, 1)), e);
      end
      K_JCOND: begin
        if (cond_true(ir[11:8], fl)) begin e.pcen = 1'b1; e.jump = 1'b1; end
        push(1'($urandom_range(0, 1)), e);
      end
      K_BR: begin
        if (cond_true(ir[11:8], fl)) begin
          e.pcen = 1'b1; e.branch = 1'b1; e.pc_mux = 1'b1; e.alusrcb = 2'd2; e.alucont = 3'd0;
        end
        push(1'($urandom_range(0, 1)), e);
      end
      default: ;
    endcase
  endtask

  // cycles < 0 lets the model decide the length; the refetch check then pins DUT latency
  task automatic run_vec(input string nm, input logic [15:0] ir, input logic [4:0] fl,
                         input int fw, input int dw, input int cycles);
    int   n;
    out_t f;
    build_trace(ir, fl, fw, dw);
    n = (cycles < 0) ? trace.size() : cycles;
    f = base_out(ir); f.mem_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin instruction = ir; flag = fl; end
      if (i < trace.size()) begin
        mem_ready = trace[i].rdy;
        #2 check($sformatf("%s[%0d]", nm, i), act, trace[i].exp);
      end else begin
        mem_ready = 1'b0;
        #2 check($sformatf("%s[%0d]_len", nm, i), act, f);
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #2 check($sformatf("%s_refetch", nm), {mem_req, iord, mem_we}, 3'b100);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"add_reg",  16'h0251, 5'b00000, 0, 0, 3});
    vecs.push_back('{"addi_neg", 16'h52FF, 5'b00000, 0, 0, 3});
    vecs.push_back('{"andi",     16'h12FF, 5'b00000, 0, 0, 3});
    vecs.push_back('{"cmp_reg",  16'h02B1, 5'b10001, 0, 0, 3});
    vecs.push_back('{"movi",     16'hD37F, 5'b00000, 1, 0, 4});
    vecs.push_back('{"load_2w",  16'h4301, 5'b00000, 0, 2, 6});
    vecs.push_back('{"stor_1w",  16'h4341, 5'b00000, 1, 1, 5});
    vecs.push_back('{"beq_tk",   16'hC005, 5'b01000, 0, 0, 3});
    vecs.push_back('{"beq_nt",   16'hC005, 5'b00000, 0, 0, 3});
    vecs.push_back('{"jal",      16'h4E83, 5'b00000, 0, 0, 3});
    vecs.push_back('{"juc",      16'h4EC3, 5'b00000, 0, 0, 3});
    vecs.push_back('{"jne_nt",   16'h41C3, 5'b01000, 0, 0, 3});
    vecs.push_back('{"bnever",   16'hC4F0, 5'b11111, 0, 0, 3});
    vecs.push_back('{"illegal",  16'hF000, 5'b00000, 0, 0, 2});
    vecs.push_back('{"bad_ext",  16'h0071, 5'b00000, 0, 0, 2});

    reset = 1'b0; mem_ready = 1'b1; instruction = 16'h4301; flag = 5'h1F;
    repeat (2) @(negedge clk);
    #2 check("reset_outputs", act, '0);
    @(negedge clk); reset = 1'b1; mem_ready = 1'b0;
    #2 check("reset_release_fetch", {mem_req, iord}, 2'b10);
    @(negedge clk);
    #2 check("fetch_hold", {mem_req, iord, ir_mux}, 3'b100);
    @(negedge clk); reset = 1'b0;
    #2 check("reset_mid_fetch", act, '0);
    @(negedge clk);
    #2 check("reset_mid_fetch_2", act, '0);
    @(negedge clk); reset = 1'b1;
    #2 check("refetch_after_reset", {mem_req, iord}, 2'b10);

    foreach (vecs[i]) run_vec(vecs[i].name, vecs[i].ir, vecs[i].fl, vecs[i].fw, vecs[i].dw, vecs[i].cycles);

    // Reset while a store is waiting: request and write strobe must vanish immediately
    @(negedge clk); instruction = 16'h4341; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    #2 check("stor_wait", {mem_req, mem_we, iord}, 3'b111);
    @(negedge clk); reset = 1'b0;
    #2 check("reset_mid_wr", act, '0);
    @(negedge clk); mem_ready = 1'b1;
    #2 check("reset_hold_wr", act, '0);
    @(negedge clk); reset = 1'b1; mem_ready = 1'b0;
    #2 check("post_wr_reset_fetch", {mem_req, mem_we, iord}, 3'b100);

    for (int t = 0; t < 150; t++) begin
      logic [15:0] ir;
      logic [3:0]  alu_codes [7];
      logic [3:0]  mem_exts  [4];
      alu_codes = '{4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hB, 4'hD};
      mem_exts  = '{4'h0, 4'h4, 4'h8, 4'hC};
      ir = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ;
        1: begin ir[15:12] = 4'h0; ir[7:4] = alu_codes[$urandom_range(0, 6)]; end
        2: ir[15:12] = ($urandom_range(0, 3) == 0) ? 4'hC : alu_codes[$urandom_range(0, 6)];
        default: begin ir[15:12] = 4'h4; ir[7:4] = mem_exts[$urandom_range(0, 3)]; end
      endcase
      run_vec($sformatf("rnd%0d_%h", t, ir), ir, 5'($urandom), $urandom_range(0, 2),
              $urandom_range(0, 2), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
